data_cache_assoc: RTL and testbench
===================================

Name: data_cache_assoc

Overview:
- Parametrised, clocked successor to the L1 data cache: N-way set-associative, write-back, write-allocate.
- Uses valid/ready handshakes on both the core side and a block-wide memory side.
- Sits between the load/store unit and main memory / L2.
- Adds a per-set round-robin replacement policy, a proper writeback-then-refill FSM and back-pressure, none of which the combinational direct-mapped cache has.

Parameters:
- ADDR_W, 16, word address width.
- WORD_W, 16, data word width.
- WORDS_PER_BLOCK, 8, words per line; power of 2, 2 or more.
- SETS, 256, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, 1 to 4.
- Derived, not overridable: OFF_W = log2(WORDS_PER_BLOCK), IDX_W = log2(SETS), TAG_W = ADDR_W - IDX_W - OFF_W.
- Address split: tag = addr[ADDR_W-1 : IDX_W+OFF_W], index = next IDX_W bits, offset = low OFF_W bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  cache can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WORD_W  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  WORD_W  load data; for a store, the newly written value.
- resp_hit  out  1  request hit without a memory access.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_write  out  1  1 = writeback, 0 = refill read.
- mem_req_addr  out  ADDR_W  block-aligned address; low OFF_W bits are 0.
- mem_wdata  out  WORDS_PER_BLOCK*WORD_W  writeback line; word i occupies bits [i*WORD_W +: WORD_W].
- mem_resp_valid  in  1  refill data valid, one cycle.
- mem_rdata  in  WORDS_PER_BLOCK*WORD_W  refill line, same packing as mem_wdata.

Behaviour:
- Reset (reset==0 at a rising edge):
  - all valid, dirty and round-robin pointers cleared; FSM to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_hit=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_wdata=0.
  - Data and tag arrays are not cleared.
  - Reset mid-miss abandons the transaction; no response is issued.
- FSM states: IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, addr and wdata, then go to LOOKUP.
  - req_ready=0 in every other state.
- LOOKUP:
  - Compare the tag against all ways of the set; a hit requires valid and a tag match.
  - Hit: a load reads the word; a store writes the word and sets dirty. resp_hit=1, go to RESP.
  - Miss: victim = first invalid way (lowest index), otherwise way rr_ptr[set]. Go to WB_REQ if the victim is valid and dirty, else RF_REQ.
- WB_REQ:
  - mem_req_valid=1, mem_req_write=1, addr = {victim tag, index, 0}, mem_wdata = victim line.
  - On mem_req_ready, clear the victim's dirty bit and go to RF_REQ.
  - Writeback is fire-and-forget: no response expected.
- RF_REQ:
  - mem_req_valid=1, mem_req_write=0, addr = {req tag, index, 0}.
  - On mem_req_ready, go to RF_WAIT.
- mem_req_* outputs stay stable while mem_req_valid=1 and mem_req_ready=0.
- RF_WAIT: on mem_resp_valid:
  - install the line; set tag, valid=1, dirty=0.
  - A store then merges req_wdata into the word and sets dirty=1.
  - Advance rr_ptr[set] = (victim+1) mod WAYS.
  - resp_hit=0; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
- Latency:
  - hit: resp_valid two cycles after the accept edge.
  - clean miss: 3 cycles plus memory latency; dirty miss adds the writeback handshake.
- Exactly one outstanding request; no core-side hit-under-miss.
- WAYS=1 degenerates to direct-mapped; rr_ptr is unused.
- mem_resp_valid outside RF_WAIT is ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs stat_hits, stat_misses and stat_wbacks, each 32 bits.
  - Incremented respectively in LOOKUP on a hit, in LOOKUP on a miss, and on the WB_REQ handshake.
  - Saturate at 2^32-1; cleared by reset.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then load 0x0010 with memory line = {0x0070,...,0x0000} (word i = 0x0010*i) -> mem refill read at 0x0010, resp_rdata=0x0000, resp_hit=0.
- Load 0x0013 immediately after -> resp_hit=1, resp_rdata=0x0030, resp_valid 2 cycles after accept, no mem_req_valid.
- Store 0xBEEF to 0x0811 (same set, tag 1) -> miss fills way 1 with no writeback; then a load of 0x0811 -> hit, 0xBEEF.
- Load 0x1010 (tag 2, set full, rr_ptr=0) evicts clean way 0 with no writeback. Then load 0x1810 (tag 3, rr_ptr=1) evicts dirty way 1 -> writeback at 0x0810 with word 1 = 0xBEEF, then refill at 0x1810.
- Hold mem_req_ready=0 for 5 cycles during WB_REQ -> mem_req_addr/mem_wdata stable, req_ready=0, resp_valid=0.
- Assert reset during RF_WAIT, then re-issue the load of 0x0010 -> no stale resp_valid, miss (valid cleared), refill re-requested.

Source files
------------

// File: rtl/data_cache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with per-set round-robin replacement.
// Optional build macro CACHE_STATS_EN adds saturating stat_hits/stat_misses/stat_wbacks counters.
module data_cache_assoc #(
  parameter int ADDR_W          = 16,
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int SETS            = 256,
  parameter int WAYS            = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [WORD_W-1:0]                 req_wdata,
  output logic                              resp_valid,
  output logic [WORD_W-1:0]                 resp_rdata,
  output logic                              resp_hit,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_write,
  output logic [ADDR_W-1:0]                 mem_req_addr,
  output logic [WORDS_PER_BLOCK*WORD_W-1:0] mem_wdata,
  input  logic                              mem_resp_valid,
  input  logic [WORDS_PER_BLOCK*WORD_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                       stat_hits,
  output logic [31:0]                       stat_misses,
  output logic [31:0]                       stat_wbacks
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = WORDS_PER_BLOCK * WORD_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT, RESP} stateT;
  stateT state, nextState;

  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [WORD_W-1:0] reqWdata;
  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [OFF_W-1:0]  reqOff;

  assign reqTag = reqAddr[ADDR_W-1 -: TAG_W];
  assign reqIdx = reqAddr[OFF_W +: IDX_W];
  assign reqOff = reqAddr[OFF_W-1:0];

  logic [LINE_W-1:0]             dataArr [WAYS][SETS];
  logic [TAG_W-1:0]              tagArr  [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0]     validBits;
  logic [SETS-1:0][WAYS-1:0]     dirtyBits;
  logic [SETS-1:0][WAY_W-1:0]    rrPtr;
  logic [WAY_W-1:0]              victimWay;

  logic              hit;
  logic [WAY_W-1:0]  hitWay;
  logic [WAY_W-1:0]  victimSel;
  logic              victimDirty;
  logic [LINE_W-1:0] hitLine;
  logic [LINE_W-1:0] victimLine;
  logic [LINE_W-1:0] storeLine;
  logic [LINE_W-1:0] fillLine;
  logic [WORD_W-1:0] hitWord;
  logic [WORD_W-1:0] fillWord;
  logic [WAY_W-1:0]  nextRr;

  // Tag match across the set, and victim choice: lowest invalid way wins over the round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    hitWay    = '0;
    victimSel = rrPtr[reqIdx];
    for (int w = 0; w < WAYS; w++) begin
      if (validBits[reqIdx][w] && tagArr[w][reqIdx] == reqTag) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validBits[reqIdx][w]) victimSel = WAY_W'(w);
    end
    victimDirty = validBits[reqIdx][victimSel] && dirtyBits[reqIdx][victimSel];
    hitLine     = dataArr[hitWay][reqIdx];
    victimLine  = dataArr[victimSel][reqIdx];
    hitWord     = hitLine[reqOff*WORD_W +: WORD_W];
    fillWord    = mem_rdata[reqOff*WORD_W +: WORD_W];
    storeLine   = hitLine;
    storeLine[reqOff*WORD_W +: WORD_W] = reqWdata;
    fillLine    = mem_rdata;
    if (reqWrite) fillLine[reqOff*WORD_W +: WORD_W] = reqWdata;
  end

  assign nextRr = (WAYS == 1) ? '0 : victimWay + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nextState = LOOKUP;
      end
      LOOKUP: begin
        if (hit)              nextState = RESP;
        else if (victimDirty) nextState = WB_REQ;
        else                  nextState = RF_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        if (mem_req_ready) nextState = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) nextState = RF_WAIT;
      end
      RF_WAIT: if (mem_resp_valid) nextState = RESP;
      RESP: begin
        resp_valid = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Memory request address/line are registered on entry to a request state so they hold under back-pressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      validBits    <= '0;
      dirtyBits    <= '0;
      rrPtr        <= '0;
      reqWrite     <= 1'b0;
      reqAddr      <= '0;
      reqWdata     <= '0;
      victimWay    <= '0;
      resp_rdata   <= '0;
      resp_hit     <= 1'b0;
      mem_req_addr <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            reqWrite <= req_write;
            reqAddr  <= req_addr;
            reqWdata <= req_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_hit   <= 1'b1;
            resp_rdata <= reqWrite ? reqWdata : hitWord;
            if (reqWrite) dirtyBits[reqIdx][hitWay] <= 1'b1;
          end else begin
            resp_hit  <= 1'b0;
            victimWay <= victimSel;
            if (victimDirty) begin
              mem_req_addr <= {tagArr[victimSel][reqIdx], reqIdx, {OFF_W{1'b0}}};
              mem_wdata    <= victimLine;
            end else begin
              mem_req_addr <= {reqTag, reqIdx, {OFF_W{1'b0}}};
            end
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            dirtyBits[reqIdx][victimWay] <= 1'b0;
            mem_req_addr                 <= {reqTag, reqIdx, {OFF_W{1'b0}}};
          end
        end
        RF_WAIT: begin
          if (mem_resp_valid) begin
            validBits[reqIdx][victimWay] <= 1'b1;
            dirtyBits[reqIdx][victimWay] <= reqWrite;
            rrPtr[reqIdx]                <= nextRr;
            resp_rdata                   <= reqWrite ? reqWdata : fillWord;
            resp_hit                     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag storage carry no reset; a store miss lands already merged into the refilled line.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == LOOKUP && hit && reqWrite) dataArr[hitWay][reqIdx] <= storeLine;
      if (state == RF_WAIT && mem_resp_valid) begin
        dataArr[victimWay][reqIdx] <= fillLine;
        tagArr[victimWay][reqIdx]  <= reqTag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
    end else begin
      if (state == LOOKUP && hit && stat_hits != '1)    stat_hits   <= stat_hits + 1'b1;
      if (state == LOOKUP && !hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      if (state == WB_REQ && mem_req_ready && stat_wbacks != '1) stat_wbacks <= stat_wbacks + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_assoc.sv
// Self-checking bench for data_cache_assoc: transaction-level cache/memory model, one per-cycle compare
// process, a back-pressuring memory responder and directed vectors with literal expectations.
module tb_data_cache_assoc;

  localparam int WAYS = 2;
  localparam int SETS = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid, req_ready, req_write;
  logic [15:0]  req_addr, req_wdata;
  logic         resp_valid, resp_hit;
  logic [15:0]  resp_rdata;
  logic         mem_req_valid, mem_req_write;
  logic         mem_req_ready = 1'b0;
  logic [15:0]  mem_req_addr;
  logic [127:0] mem_wdata;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  stat_hits, stat_misses, stat_wbacks;
`endif

  data_cache_assoc dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit           write;
    logic [15:0]  addr;
    logic [127:0] line;
  } memExpT;

  memExpT      expQ[$];
  logic [15:0] archMem  [logic [15:0]];
  logic [15:0] benchMem [logic [15:0]];
  bit          mValid [WAYS][SETS];
  bit          mDirty [WAYS][SETS];
  logic [4:0]  mTag   [WAYS][SETS];
  int          mRr    [SETS];

  int           assertions = 0;
  int           failures = 0;
  bit           busy = 1'b0;
  int           cyc = 0;
  logic [15:0]  expRdata;
  bit           expHit;
  logic [15:0]  lastRdata, lastWbAddr, lastRfAddr;
  logic [127:0] lastWbLine;
  bit           lastHit;
  int           lastLat, wbCount = 0, rfCount = 0, stallSeen = 0, stallWb = 0;
  bit           pending = 1'b0;
  int           lat = 0;
  logic [15:0]  pendAddr;

  function automatic logic [15:0] memInit(input logic [15:0] a);
    logic [15:0] b;
    b = (a >> 3) ^ 16'h0002;
    return ({13'd0, a[2:0]} << 4) ^ (b * 16'h0101);
  endfunction

  function automatic logic [15:0] archRead(input logic [15:0] a);
    return archMem.exists(a) ? archMem[a] : memInit(a);
  endfunction

  function automatic logic [15:0] benchRead(input logic [15:0] a);
    return benchMem.exists(a) ? benchMem[a] : memInit(a);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: actual=event required=no event", name);
  endtask

  // A reset drops every cached line, so the core view falls back to main-memory contents.
  task automatic modelReset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        mValid[w][s] = 1'b0;
        mDirty[w][s] = 1'b0;
        mTag[w][s]   = '0;
      end
    for (int s = 0; s < SETS; s++) mRr[s] = 0;
    archMem = benchMem;
    expQ.delete();
    busy = 1'b0;
  endtask

  task automatic modelRequest(input bit wr, input logic [15:0] a, input logic [15:0] d);
    logic [7:0]   idx;
    logic [4:0]   tag;
    int           hitW, v;
    memExpT       e;
    idx  = a[10:3];
    tag  = a[15:11];
    hitW = -1;
    for (int w = 0; w < WAYS; w++)
      if (mValid[w][idx] && mTag[w][idx] == tag) hitW = w;
    if (hitW >= 0) begin
      expHit = 1'b1;
      if (wr) mDirty[hitW][idx] = 1'b1;
    end else begin
      expHit = 1'b0;
      v = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (!mValid[w][idx]) v = w;
      if (v < 0) v = mRr[idx];
      if (mValid[v][idx] && mDirty[v][idx]) begin
        e.write = 1'b1;
        e.addr  = {mTag[v][idx], idx, 3'b000};
        for (int i = 0; i < 8; i++) e.line[i*16 +: 16] = archRead(e.addr + 16'(i));
        expQ.push_back(e);
      end
      e.write = 1'b0;
      e.addr  = {a[15:3], 3'b000};
      e.line  = '0;
      expQ.push_back(e);
      mTag[v][idx]   = tag;
      mValid[v][idx] = 1'b1;
      mDirty[v][idx] = wr;
      mRr[idx]       = (v + 1) % WAYS;
    end
    if (wr) archMem[a] = d;
    expRdata = wr ? d : archRead(a);
  endtask

  task automatic applyStimulus(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      failNow("req_ready_timeout");
      return;
    end
    modelRequest(wr, a, d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc       = 0;
    busy      = 1'b1;
  endtask

  task automatic waitResp();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    failNow("resp_timeout");
    busy = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1'b1);
    checkOutput({tag, "_resp_valid"}, resp_valid, 1'b0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 16'h0000);
    checkOutput({tag, "_resp_hit"}, resp_hit, 1'b0);
    checkOutput({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    checkOutput({tag, "_mem_req_write"}, mem_req_write, 1'b0);
    checkOutput({tag, "_mem_req_addr"}, mem_req_addr, 16'h0000);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 128'h0);
  endtask

  // Memory side: drives just after each rising edge; writebacks can be stalled, refills return two cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      if (!reset) begin
        pending = 1'b0;
      end else if (pending) begin
        if (lat == 0) begin
          mem_resp_valid = 1'b1;
          for (int i = 0; i < 8; i++) mem_rdata[i*16 +: 16] = benchRead(pendAddr + 16'(i));
          pending = 1'b0;
        end else begin
          lat--;
        end
      end else if (mem_req_valid) begin
        if (mem_req_write && stallWb > 0) begin
          stallWb--;
        end else begin
          mem_req_ready = 1'b1;
          if (mem_req_write) begin
            for (int i = 0; i < 8; i++) benchMem[mem_req_addr + 16'(i)] = mem_wdata[i*16 +: 16];
          end else begin
            pending  = 1'b1;
            lat      = 1;
            pendAddr = mem_req_addr;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        checkOutput("req_ready", req_ready, !busy);
        if (busy) cyc++;
        if (resp_valid) begin
          if (!busy) begin
            failNow("stale_resp_valid");
          end else begin
            checkOutput("resp_rdata", resp_rdata, expRdata);
            checkOutput("resp_hit", resp_hit, expHit);
            checkOutput("mem_pending_at_resp", expQ.size(), 0);
            if (expHit) checkOutput("hit_latency", cyc, 2);
            lastRdata = resp_rdata;
            lastHit   = resp_hit;
            lastLat   = cyc;
            busy      = 1'b0;
          end
        end
        if (mem_req_valid) begin
          if (expQ.size() == 0) begin
            failNow("unexpected_mem_req");
          end else begin
            checkOutput("mem_req_write", mem_req_write, expQ[0].write);
            checkOutput("mem_req_addr", mem_req_addr, expQ[0].addr);
            if (expQ[0].write) checkOutput("mem_wdata", mem_wdata, expQ[0].line);
            if (mem_req_write && !mem_req_ready) stallSeen++;
            if (mem_req_ready) begin
              if (expQ[0].write) begin
                wbCount++;
                lastWbAddr = mem_req_addr;
                lastWbLine = mem_wdata;
              end else begin
                rfCount++;
                lastRfAddr = mem_req_addr;
              end
              void'(expQ.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int rfBefore;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    reset = 1'b1;

    applyStimulus(1'b0, 16'h0010, 16'h0000); waitResp();
    checkOutput("ld0010_rdata", lastRdata, 16'h0000);
    checkOutput("ld0010_hit", lastHit, 1'b0);
    checkOutput("ld0010_rf_addr", lastRfAddr, 16'h0010);

    applyStimulus(1'b0, 16'h0013, 16'h0000); waitResp();
    checkOutput("ld0013_rdata", lastRdata, 16'h0030);
    checkOutput("ld0013_hit", lastHit, 1'b1);
    checkOutput("ld0013_latency", lastLat, 2);

    applyStimulus(1'b1, 16'h0811, 16'hBEEF); waitResp();
    checkOutput("st0811_hit", lastHit, 1'b0);
    checkOutput("st0811_rdata", lastRdata, 16'hBEEF);
    checkOutput("st0811_no_wb", wbCount, 0);

    applyStimulus(1'b0, 16'h0811, 16'h0000); waitResp();
    checkOutput("ld0811_hit", lastHit, 1'b1);
    checkOutput("ld0811_rdata", lastRdata, 16'hBEEF);

    applyStimulus(1'b0, 16'h1010, 16'h0000); waitResp();
    checkOutput("ld1010_hit", lastHit, 1'b0);
    checkOutput("ld1010_rdata", lastRdata, 16'h0200);
    checkOutput("ld1010_no_wb", wbCount, 0);

    stallSeen = 0;
    stallWb   = 5;
    applyStimulus(1'b0, 16'h1810, 16'h0000); waitResp();
    checkOutput("ld1810_wb_count", wbCount, 1);
    checkOutput("ld1810_wb_addr", lastWbAddr, 16'h0810);
    checkOutput("ld1810_wb_word1", lastWbLine[31:16], 16'hBEEF);
    checkOutput("ld1810_wb_word0", lastWbLine[15:0], 16'h0100);
    checkOutput("ld1810_stall_cycles", stallSeen, 5);
    checkOutput("ld1810_rf_addr", lastRfAddr, 16'h1810);
    checkOutput("ld1810_rdata", lastRdata, 16'h0300);

    applyStimulus(1'b1, 16'h1813, 16'h1234); waitResp();
    checkOutput("st1813_hit", lastHit, 1'b1);
    checkOutput("st1813_rdata", lastRdata, 16'h1234);
    applyStimulus(1'b0, 16'h1012, 16'h0000); waitResp();
    checkOutput("ld1012_hit", lastHit, 1'b1);

    // Reset while the refill of 0x0010 is outstanding; the dirty 0x1813 store is lost with it.
    rfBefore = rfCount;
    applyStimulus(1'b0, 16'h0010, 16'h0000);
    for (int i = 0; i < 100 && rfCount == rfBefore; i++) @(negedge clk);
    if (rfCount == rfBefore) failNow("refill_req_timeout");
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("midmiss");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus(1'b0, 16'h0010, 16'h0000); waitResp();
    checkOutput("reld0010_hit", lastHit, 1'b0);
    checkOutput("reld0010_rdata", lastRdata, 16'h0000);
    checkOutput("reld0010_rf_addr", lastRfAddr, 16'h0010);
    applyStimulus(1'b0, 16'h1813, 16'h0000); waitResp();
    checkOutput("ld1813_hit", lastHit, 1'b0);
    checkOutput("ld1813_rdata", lastRdata, 16'h0330);

    repeat (3) @(negedge clk);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
